pkt_out_drainer: RTL and testbench

//  Read side of fifo_sram: pops 72-bit {ctrl,data} words via reb/fifo_output/fifo_empty and emits them on the

---
 rtl/pkt_stream_pkg.sv | 19 +
 rtl/pkt_out_drainer_if.sv | 26 ++
 rtl/pkt_skid_buf.sv | 52 +++++
 rtl/pkt_out_drainer.sv | 114 +++++++++++
 tb/tb_pkt_out_drainer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_stream_pkg.sv
// Shared constants, word layout and FSM state type for the packet output path.
package pkt_stream_pkg;

    localparam int FIFO_WORD_W = 72;
    localparam logic [7:0] CTRL_MOD_HDR = 8'hFF;
    localparam logic [7:0] CTRL_BODY = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        BODY
    } pkt_state_e;

    // An end-of-packet word carries a one-hot byte mask, never 00 or FF
    function automatic logic is_eop(input logic [7:0] ctrl);
        return (ctrl != CTRL_BODY) && (ctrl != CTRL_MOD_HDR);
    endfunction

endpackage

// File: rtl/pkt_out_drainer_if.sv
// FIFO read port plus NetFPGA-style output stream of pkt_out_drainer.
interface pkt_out_drainer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8
);
    import pkt_stream_pkg::*;

    logic                   fifo_empty;
    logic [FIFO_WORD_W-1:0] fifo_output;
    logic                   reb;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [CTRL_WIDTH-1:0]  out_ctrl;
    logic                   out_wr;
    logic                   out_rdy;

    modport master (
        input  fifo_empty, fifo_output, out_rdy,
        output reb, out_data, out_ctrl, out_wr
    );

    modport slave (
        output fifo_empty, fifo_output, out_rdy,
        input  reb, out_data, out_ctrl, out_wr
    );

endinterface

// File: rtl/pkt_skid_buf.sv
// Two-entry register FIFO that absorbs the one-cycle SRAM read latency.
module pkt_skid_buf #(
    parameter int W = 72
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   occ
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_q, wr_d;
    logic         rd_q, rd_d;
    logic [1:0]   occ_q, occ_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = din;
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    assign head = mem_q[rd_q];
    assign occ  = occ_q;

endmodule

// File: rtl/pkt_out_drainer.sv
// Drains fifo_sram onto the output stream with packet-boundary gating.
// Optional statistics counters: build with PKT_STATS_EN defined.
module pkt_out_drainer
    import pkt_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pc_en,
    pkt_out_drainer_if.master     io,
    output logic                  in_pkt,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    pkt_state_e             state_q, state_d;
    logic                   inflight_q, inflight_d;
    logic [FIFO_WORD_W-1:0] head;
    logic [1:0]             occ;
    logic [2:0]             load;
    logic [CTRL_WIDTH-1:0]  cap_ctrl;
    logic                   push, pop, allow, reb;

    assign push     = inflight_q;
    assign pop      = (occ != 2'd0) & io.out_rdy & ~reset;
    assign cap_ctrl = io.fifo_output[DATA_WIDTH +: CTRL_WIDTH];

    pkt_skid_buf #(.W(FIFO_WORD_W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (io.fifo_output),
        .pop   (pop),
        .head  (head),
        .occ   (occ)
    );

    always_comb begin
        state_d = state_q;
        if (push) begin
            unique case (state_q)
                IDLE: begin
                    if (cap_ctrl == CTRL_MOD_HDR) state_d = HDR;
                    else if (cap_ctrl == CTRL_BODY) state_d = BODY;
                end
                HDR: begin
                    if (cap_ctrl == CTRL_BODY) state_d = BODY;
                end
                BODY: begin
                    if (cap_ctrl != CTRL_BODY) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        // The EOP being captured already closes the packet for read gating
        allow = (state_d == IDLE) ? pc_en : 1'b1;
        // A slot freed by this cycle's pop is usable, giving full throughput
        load = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
        reb = ~reset & ~io.fifo_empty & allow & (load < 3'd2);
        inflight_d = reb;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end
    end

    assign io.reb      = reb;
    assign io.out_wr   = pop;
    assign io.out_data = head[DATA_WIDTH-1:0];
    assign io.out_ctrl = head[DATA_WIDTH +: CTRL_WIDTH];
    assign in_pkt      = (state_q != IDLE);

`ifdef PKT_STATS_EN
    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        word_cnt_d = word_cnt_q;
        if (pop) begin
            word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
            if (is_eop(head[DATA_WIDTH +: CTRL_WIDTH])) begin
                pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign word_cnt = word_cnt_q;
`else
    assign pkt_cnt  = '0;
    assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_out_drainer.sv
// Self-checking bench for pkt_out_drainer: cycle table plus scoreboarded random traffic.
module tb_pkt_out_drainer;
    import pkt_stream_pkg::*;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NW = 32;
`ifdef PKT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pc_en = 1'b1;
    logic          in_pkt;
    logic [NW-1:0] pkt_cnt;
    logic [NW-1:0] word_cnt;

    pkt_out_drainer_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dif ();

    pkt_out_drainer #(
        .DATA_WIDTH (DW),
        .CTRL_WIDTH (CW),
        .CNT_WIDTH  (NW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pc_en    (pc_en),
        .io       (dif),
        .in_pkt   (in_pkt),
        .pkt_cnt  (pkt_cnt),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: word appears on fifo_output the cycle after reb
    logic [71:0] fifo_q[$];
    logic        empty_r = 1'b1;
    logic        force_empty = 1'b0;
    int          rd_cnt = 0;

    assign dif.fifo_empty = empty_r | force_empty;

    always @(posedge clk) begin
        if (dif.reb && fifo_q.size() > 0) begin
            dif.fifo_output <= fifo_q.pop_front();
            rd_cnt <= rd_cnt + 1;
        end
        if (reset) rd_cnt <= 0;
        empty_r <= (fifo_q.size() == 0);
    end

    // Reference: output stream equals the written stream, in order
    logic [71:0] exp_q[$];
    logic [31:0] seq = 32'd1;
    int          tot_words = 0;
    int          tot_pkts = 0;
    int          wr_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        prev_rdy = 1'b1;
    logic [71:0] prev_word = '0;

    task automatic chk(input string name, input logic [71:0] act,
                       input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [71:0] cur;
        cur = {dif.out_ctrl, dif.out_data};
        chk("outstanding_le2", ((rd_cnt - wr_cnt) <= 2), 1);
        if (!prev_rdy && exp_q.size() > 0 && prev_word == exp_q[0])
            chk("stall_stable", cur, prev_word);
        if (!dif.out_rdy) chk("no_wr_stalled", dif.out_wr, 0);
        if (dif.out_wr) begin
            wr_cnt++;
            chk("word_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() > 0) chk("word_order", cur, exp_q.pop_front());
        end
        prev_rdy = dif.out_rdy;
        prev_word = cur;
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic push_word(input logic [7:0] c);
        logic [71:0] w;
        w = {c, seq, 32'hC0DE0000 ^ seq};
        seq++;
        fifo_q.push_back(w);
        exp_q.push_back(w);
        tot_words++;
    endtask

    task automatic push_pkt(input bit hdr, input int nbody, input logic [7:0] eop);
        if (hdr) push_word(CTRL_MOD_HDR);
        repeat (nbody) push_word(CTRL_BODY);
        push_word(eop);
        tot_pkts++;
    endtask

    task automatic drain(input int max_cyc, input int mode, input string name);
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0 && fifo_q.size() == 0) break;
            if (mode == 1) dif.out_rdy = ~dif.out_rdy;
            else if (mode == 2) dif.out_rdy = ($urandom_range(0, 3) != 0);
            else dif.out_rdy = 1'b1;
            tick();
        end
        chk(name, exp_q.size(), 0);
        dif.out_rdy = 1'b1;
        repeat (3) tick();
    endtask

    task automatic chk_cnt(input string name);
        chk({name, "_pkt_cnt"}, pkt_cnt, STATS ? tot_pkts : 0);
        chk({name, "_word_cnt"}, word_cnt, STATS ? tot_words : 0);
    endtask

    typedef struct {
        logic        rdy;
        logic        reb;
        logic        wr;
        int          widx;
        logic        in_pkt;
    } vec_t;

    vec_t        tv[8];
    logic [71:0] pk[5];

    initial begin
        dif.out_rdy = 1'b1;
        dif.fifo_output = '0;

        // Reset held with a full packet waiting in the FIFO
        push_pkt(1'b1, 3, 8'h80);
        for (int i = 0; i < 5; i++) pk[i] = exp_q[i];
        repeat (3) @(posedge clk);
        #1;
        sample();
        chk("rst_reb", dif.reb, 0);
        chk("rst_out_wr", dif.out_wr, 0);
        chk("rst_out_data", dif.out_data, 0);
        chk("rst_out_ctrl", dif.out_ctrl, 0);
        chk("rst_in_pkt", in_pkt, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_no_reads", fifo_q.size(), 5);
        advance();
        reset = 1'b0;

        // Cycle-exact first packet: reb at row 0, five words from row 2
        tv[0] = '{1'b1, 1'b1, 1'b0, -1, 1'b0};
        tv[1] = '{1'b1, 1'b1, 1'b0, -1, 1'b0};
        tv[2] = '{1'b1, 1'b1, 1'b1, 0, 1'b1};
        tv[3] = '{1'b1, 1'b1, 1'b1, 1, 1'b1};
        tv[4] = '{1'b1, 1'b1, 1'b1, 2, 1'b1};
        tv[5] = '{1'b1, 1'b0, 1'b1, 3, 1'b1};
        tv[6] = '{1'b1, 1'b0, 1'b1, 4, 1'b0};
        tv[7] = '{1'b1, 1'b0, 1'b0, -1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            dif.out_rdy = tv[i].rdy;
            @(negedge clk);
            chk($sformatf("t2_reb[%0d]", i), dif.reb, tv[i].reb);
            chk($sformatf("t2_wr[%0d]", i), dif.out_wr, tv[i].wr);
            chk($sformatf("t2_in_pkt[%0d]", i), in_pkt, tv[i].in_pkt);
            if (tv[i].wr)
                chk($sformatf("t2_word[%0d]", i), {dif.out_ctrl, dif.out_data},
                    pk[tv[i].widx]);
            monitor();
            advance();
        end
        chk("t2_drained", exp_q.size(), 0);
        chk_cnt("t2");

        // Toggling out_rdy: order, stability and bounded occupancy
        push_pkt(1'b1, 3, 8'h80);
        drain(60, 1, "t3_drained");
        chk_cnt("t3");

        // pc_en dropped inside packet 1 of two
        push_pkt(1'b1, 3, 8'h80);
        push_pkt(1'b1, 2, 8'h04);
        begin
            int i;
            for (i = 0; i < 30; i++) begin
                tick();
                if (exp_q.size() <= 7) break;
            end
            chk("t4_two_words_out", (exp_q.size() <= 7), 1);
        end
        pc_en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() <= 4) break;
            tick();
        end
        chk("t4_pkt1_done", exp_q.size(), 4);
        for (int i = 0; i < 3; i++) begin
            sample();
            chk($sformatf("t4_hold_reb[%0d]", i), dif.reb, 0);
            chk($sformatf("t4_hold_in_pkt[%0d]", i), in_pkt, 0);
            advance();
        end
        chk("t4_pkt2_in_fifo", fifo_q.size(), 4);
        pc_en = 1'b1;
        sample();
        chk("t4_resume_reb", dif.reb, 1);
        advance();
        drain(40, 0, "t4_drained");
        chk_cnt("t4");

        // FIFO empty for four cycles in the middle of a body
        push_pkt(1'b0, 7, 8'h01);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (exp_q.size() <= 5) break;
        end
        force_empty = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk($sformatf("t5_in_pkt[%0d]", i), in_pkt, 1);
            chk($sformatf("t5_reb[%0d]", i), dif.reb, 0);
            if (i >= 2) chk($sformatf("t5_wr_stop[%0d]", i), dif.out_wr, 0);
            advance();
        end
        force_empty = 1'b0;
        drain(40, 0, "t5_drained");
        chk_cnt("t5");

        // Reset with the skid buffer full mid-packet
        dif.out_rdy = 1'b0;
        push_pkt(1'b1, 6, 8'h10);
        repeat (8) tick();
        sample();
        chk("t6_skid_full", rd_cnt - wr_cnt, 2);
        chk("t6_in_pkt", in_pkt, 1);
        advance();
        reset = 1'b1;
        dif.out_rdy = 1'b1;
        sample();
        chk("t6_rst_wr", dif.out_wr, 0);
        advance();
        reset = 1'b0;
        pc_en = 1'b0;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        wr_cnt = 0;
        tot_words = 0;
        tot_pkts = 0;
        sample();
        chk("t6_wr_after", dif.out_wr, 0);
        chk("t6_in_pkt_after", in_pkt, 0);
        chk("t6_reb_after", dif.reb, 0);
        chk("t6_pkt_cnt", pkt_cnt, 0);
        chk("t6_word_cnt", word_cnt, 0);
        chk("t6_rest_in_fifo", fifo_q.size(), 6);
        advance();
        fifo_q.delete();
        exp_q.delete();
        repeat (2) tick();
        pc_en = 1'b1;

        // Random traffic, stalls, empties and pc_en gaps
        begin
            int sent;
            sent = 0;
            for (int c = 0; c < 6000; c++) begin
                if (sent == 30 && exp_q.size() == 0 && fifo_q.size() == 0) break;
                if (sent < 30 && $urandom_range(0, 5) == 0) begin
                    push_pkt(($urandom_range(0, 1) == 1), $urandom_range(1, 5),
                             8'h01 << $urandom_range(0, 7));
                    sent++;
                end
                dif.out_rdy = ($urandom_range(0, 3) != 0);
                pc_en = ($urandom_range(0, 9) != 0);
                force_empty = ($urandom_range(0, 9) == 0);
                tick();
            end
            chk("t7_all_sent", sent, 30);
        end
        pc_en = 1'b1;
        force_empty = 1'b0;
        drain(200, 2, "t7_drained");
        chk("t7_idle", in_pkt, 0);
        chk_cnt("t7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
